// File: rtl/channel_rd_reader.sv
// channel_rd_reader: drains the SDRAM read channel's line buffer into a
// line-tagged 16-bit pixel stream with a valid/ready handshake.
// The fill pointer from the write side limits how far reads may run ahead,
// and a small skid FIFO absorbs the one-cycle buffer read latency.
// All state advances on the falling clock edge, matching the read channel.
module channel_rd_reader #(
  parameter int FIFO_DEPTH  = 2,
  parameter int BUF_WORDS16 = 1024
) (
  input  logic        clk,
  input  logic        init,
  input  logic        frame_start,
  input  logic [9:0]  line_words,
  input  logic [13:0] num_lines,
  input  logic [10:0] ao,
  output logic [11:0] ch1a,
  input  logic [15:0] obdat,
  input  logic        dst_rdy,
  output logic [15:0] dout,
  output logic        dv,
  output logic        sol,
  output logic        eol,
  output logic        busy,
  output logic        frame_done,
  output logic [11:0] level,
  output logic        overrun
);

  // Frame control states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Skid FIFO geometry; the index wraps explicitly so non-power-of-two depths work.
  localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_IDX = PW'(FIFO_DEPTH - 1);
  localparam logic [12:0]     BUF_LIM  = 13'(BUF_WORDS16);

  // Registered state and next-state values.
  logic [1:0]    state_q,      state_d;
  logic [11:0]   rd_ptr_q,     rd_ptr_d;
  logic [11:0]   level_q,      level_d;
  logic [9:0]    lw_q,         lw_d;
  logic [13:0]   nl_q,         nl_d;
  logic [9:0]    word_cnt_q,   word_cnt_d;
  logic [13:0]   line_cnt_q,   line_cnt_d;
  logic          inflight_q,   inflight_d;
  logic          infl_sol_q,   infl_sol_d;
  logic          infl_eol_q,   infl_eol_d;
  logic [PW-1:0] wr_idx_q,     wr_idx_d;
  logic [PW-1:0] rd_idx_q,     rd_idx_d;
  logic [CW-1:0] count_q,      count_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q,    overrun_d;

  // FIFO storage: {sol, eol, data}.
  logic [17:0] fifo_mem [FIFO_DEPTH];
  logic [17:0] head;

  // Decoded per-cycle conditions.
  logic [11:0] avail;
  logic        fifo_room;
  logic        issue;
  logic        tag_sol;
  logic        tag_eol;
  logic        last_word;
  logic        push;
  logic        pop;

  // Words written but not yet issued, from the live pointers. The registered
  // level output lags by one cycle, so gating issue on it could read past the
  // fill pointer right after a burst of issues.
  assign avail     = {ao, 1'b0} - rd_ptr_q;
  // Space is reserved for the in-flight word and a pop is never counted on,
  // so a stalled consumer cannot cause an overflow.
  assign fifo_room = (count_q + CW'(inflight_q)) < DEPTH_C;
  assign issue     = (state_q == ST_RUN) && (avail != 12'd0) && fifo_room;
  // line_words of 0 means 1024; the 10-bit subtraction wraps to 1023 for that.
  assign tag_sol   = (word_cnt_q == 10'd0);
  assign tag_eol   = (word_cnt_q == (lw_q - 10'd1));
  assign last_word = tag_eol && (line_cnt_q == nl_q);
  assign push      = inflight_q;
  assign pop       = dv && dst_rdy;

  // Outputs: FIFO head when valid, forced to zero when empty so reset leaves
  // a clean bus without having to clear the storage.
  assign head       = fifo_mem[rd_idx_q];
  assign dv         = (count_q != '0);
  assign dout       = dv ? head[15:0] : 16'd0;
  assign sol        = dv & head[17];
  assign eol        = dv & head[16];
  assign busy       = (state_q != ST_IDLE);
  assign ch1a       = rd_ptr_q;
  assign level      = level_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

  // Next-state logic for the frame FSM, read issue, tagging and FIFO bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and infers a latch.
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    lw_d         = lw_q;
    nl_d         = nl_q;
    word_cnt_d   = word_cnt_q;
    line_cnt_d   = line_cnt_q;
    inflight_d   = issue;
    infl_sol_d   = infl_sol_q;
    infl_eol_d   = infl_eol_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    level_d      = avail;
    overrun_d    = overrun_q | ({1'b0, level_q} > BUF_LIM);

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d    = ST_RUN;
          lw_d       = line_words;
          nl_d       = num_lines;
          word_cnt_d = 10'd0;
          line_cnt_d = 14'd0;
        end
      end
      ST_RUN: begin
        if (issue && last_word) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((count_q == '0) && !inflight_q) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Issue: advance the address and tag the word by its position in the line.
    if (issue) begin
      rd_ptr_d   = rd_ptr_q + 12'd1;
      infl_sol_d = tag_sol;
      infl_eol_d = tag_eol;
      if (tag_eol) begin
        word_cnt_d = 10'd0;
        line_cnt_d = line_cnt_q + 14'd1;
      end else begin
        word_cnt_d = word_cnt_q + 10'd1;
      end
    end

    // Capture of last cycle's read and consumer pop may coincide.
    if (push) begin
      wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + PW'(1);
    end
    if (pop) begin
      rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // State registers with synchronous abort/reset on init.
  always_ff @(negedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (init) begin
      state_q      <= ST_IDLE;
      rd_ptr_q     <= 12'd0;
      level_q      <= 12'd0;
      lw_q         <= 10'd0;
      nl_q         <= 14'd0;
      word_cnt_q   <= 10'd0;
      line_cnt_q   <= 14'd0;
      inflight_q   <= 1'b0;
      infl_sol_q   <= 1'b0;
      infl_eol_q   <= 1'b0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      lw_q         <= lw_d;
      nl_q         <= nl_d;
      word_cnt_q   <= word_cnt_d;
      line_cnt_q   <= line_cnt_d;
      inflight_q   <= inflight_d;
      infl_sol_q   <= infl_sol_d;
      infl_eol_q   <= infl_eol_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // FIFO write: buffer data returned for the read issued one edge earlier.
  always_ff @(negedge clk) begin
    // NOTE: the storage array has no reset; occupancy is cleared instead and
    // the outputs are masked while empty, so stale entries are never visible.
    if (push) begin
      fifo_mem[wr_idx_q] <= {infl_sol_q, infl_eol_q, obdat};
    end
  end

endmodule

// File: tb/tb_channel_rd_reader.sv
// Self-checking bench for channel_rd_reader. Expected pixel streams are built
// per frame from the line geometry and the running read address; a buffer
// model returns per-address data one edge after the address is presented.
module tb_channel_rd_reader;

  logic        clk;
  logic        init;
  logic        frame_start;
  logic [9:0]  line_words;
  logic [13:0] num_lines;
  logic [10:0] ao;
  logic [11:0] ch1a;
  logic [15:0] obdat;
  logic        dst_rdy;
  logic [15:0] dout;
  logic        dv;
  logic        sol;
  logic        eol;
  logic        busy;
  logic        frame_done;
  logic [11:0] level;
  logic        overrun;

  channel_rd_reader #(
    .FIFO_DEPTH (2),
    .BUF_WORDS16(1024)
  ) dut (
    .clk        (clk),
    .init       (init),
    .frame_start(frame_start),
    .line_words (line_words),
    .num_lines  (num_lines),
    .ao         (ao),
    .ch1a       (ch1a),
    .obdat      (obdat),
    .dst_rdy    (dst_rdy),
    .dout       (dout),
    .dv         (dv),
    .sol        (sol),
    .eol        (eol),
    .busy       (busy),
    .frame_done (frame_done),
    .level      (level),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line buffer: 1024 words, registered read on the channel's active edge.
  logic [15:0] mem [1024];
  always @(negedge clk) obdat <= mem[ch1a[9:0]];

  typedef struct packed {
    logic [15:0] data;
    logic        s;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          fd_due = -1;
  int          fd_cnt = 0;
  int          rdy_mode = 0;
  int          bp_cnt = 0;
  logic        init_req = 1'b1;
  logic        fs_req = 1'b0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_word = '0;
  logic [11:0] model_ptr = '0;
  logic [11:0] base_ptr = '0;
  logic [10:0] ao_target = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: check outputs seen after the last active edge, then drive
  // inputs for the next one and score any handshake that will complete.
  task automatic cycle();
    logic [11:0] iss;
    logic [11:0] av;
    exp_t        e;
    @(posedge clk);
    cyc++;
    if (prev_stall) begin
      check("stall_dv", 32'(dv), 32'd1);
      check("stall_word", 32'({sol, eol, dout}), 32'(prev_word));
    end
    if (frame_done || (cyc == fd_due)) begin
      check("frame_done_timing", 32'(frame_done), 32'(cyc == fd_due));
    end
    if (frame_done) fd_cnt++;
    if (busy) begin
      iss = ch1a - base_ptr;
      av  = {ao, 1'b0} - base_ptr;
      check("no_overread", 32'(iss <= av), 32'd1);
    end

    init        = init_req;
    frame_start = fs_req;
    fs_req      = 1'b0;
    case (rdy_mode)
      0:       dst_rdy = 1'b1;
      1:       dst_rdy = ($urandom_range(0, 3) != 0);
      default: begin
        dst_rdy = (bp_cnt >= 6 && bp_cnt < 11) ? 1'b0 : (bp_cnt % 2 == 0);
        bp_cnt++;
      end
    endcase
    av = {ao, 1'b0} - ch1a;
    if ((ao != ao_target) && (av < 12'd64) && ($urandom_range(0, 1) == 1)) ao = ao + 11'd1;

    if (dv && dst_rdy && !init) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(e.data));
        check("sol", 32'(sol), 32'(e.s));
        check("eol", 32'(eol), 32'(e.e));
        if (exp_q.size() == 0) fd_due = cyc + 2;
      end
    end
    prev_stall = dv && !dst_rdy && !init;
    prev_word  = {sol, eol, dout};
  endtask

  // Build the expected stream from line geometry and the running address.
  task automatic start_frame(input logic [9:0] lw, input logic [13:0] nl, input bit jump);
    int   len;
    int   n;
    int   addr;
    int   fin;
    exp_t e;
    len = (lw == 10'd0) ? 1024 : int'(lw);
    n   = len * (int'(nl) + 1);
    base_ptr = model_ptr;
    for (int i = 0; i < n; i++) begin
      addr   = (int'(model_ptr) + i) % 4096;
      e.data = mem[addr % 1024];
      e.s    = (i % len == 0);
      e.e    = (i % len == len - 1);
      exp_q.push_back(e);
    end
    fin       = (int'(model_ptr) + n) % 4096;
    model_ptr = 12'(fin);
    ao_target = 11'((fin + 1) / 2);
    if (jump) ao = ao_target;
    line_words = lw;
    num_lines  = nl;
    fs_req     = 1'b1;
    fd_cnt     = 0;
    bp_cnt     = 0;
  endtask

  task automatic finish_frame(input int budget);
    logic [11:0] lv;
    for (int i = 0; i < budget && fd_cnt == 0; i++) cycle();
    check("frame_done_seen", 32'(fd_cnt), 32'd1);
    repeat (3) cycle();
    check("single_frame_done", 32'(fd_cnt), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("rd_ptr", 32'(ch1a), 32'(model_ptr));
    lv = {ao, 1'b0} - model_ptr;
    check("level_idle", 32'(level), 32'(lv));
  endtask

  task automatic run_frame(input logic [9:0] lw, input logic [13:0] nl, input int mode, input bit jump);
    int len;
    len      = (lw == 10'd0) ? 1024 : int'(lw);
    rdy_mode = mode;
    start_frame(lw, nl, jump);
    finish_frame(len * (int'(nl) + 1) * 8 + 200);
  endtask

  initial begin
    int          n;
    logic [10:0] tgt;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    init        = 1'b1;
    frame_start = 1'b0;
    line_words  = '0;
    num_lines   = '0;
    ao          = '0;
    dst_rdy     = 1'b0;

    // Reset state.
    repeat (3) cycle();
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_flags", 32'({dv, sol, eol, busy, frame_done, overrun}), 32'd0);
    check("rst_ch1a", 32'(ch1a), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    init_req = 1'b0;
    cycle();

    // Basic line: 8 words from addresses 0..7.
    run_frame(10'd8, 14'd0, 0, 1'b1);

    // Starvation: no data for 20 cycles, then 4 words arrive.
    rdy_mode = 0;
    start_frame(10'd4, 14'd0, 1'b0);
    tgt       = ao_target;
    ao_target = ao;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("starve_ch1a", 32'(ch1a), 32'(base_ptr));
      check("starve_dv", 32'(dv), 32'd0);
    end
    ao_target = tgt;
    ao        = tgt;
    finish_frame(200);

    // Backpressure with a 5-cycle stall.
    run_frame(10'd16, 14'd0, 2, 1'b1);

    // Multi-line frame, random ready.
    run_frame(10'd3, 14'd2, 1, 1'b0);

    // Randomised frames, including single-word lines and a 1024-word line.
    run_frame(10'd1, 14'd3, 1, 1'b0);
    for (int f = 0; f < 4; f++) begin
      run_frame(10'($urandom_range(1, 24)), 14'($urandom_range(0, 3)), 1, 1'b0);
    end
    run_frame(10'd0, 14'd0, 0, 1'b0);

    // Bring the read pointer to 4094, then read across the wrap.
    n = (4094 - int'(model_ptr) + 4096) % 4096;
    if (n % 1024 != 0) run_frame(10'(n % 1024), 14'd0, 0, 1'b0);
    if (n / 1024 != 0) run_frame(10'd0, 14'(n / 1024 - 1), 0, 1'b0);
    check("wrap_start_ptr", 32'(ch1a), 32'd4094);
    check("wrap_start_page", 32'(ch1a[11:10]), 32'd3);
    check("wrap_start_ao", 32'(ao), 32'd2047);
    run_frame(10'd4, 14'd0, 1, 1'b0);
    check("wrap_end_page", 32'(ch1a[11:10]), 32'd0);
    check("wrap_end_ao", 32'(ao), 32'd1);

    // Abort mid-line: no frame_done, everything idle on the next edge.
    rdy_mode = 1;
    start_frame(10'd8, 14'd3, 1'b1);
    for (int i = 0; i < 50 && !dv; i++) cycle();
    check("abort_dv_seen", 32'(dv), 32'd1);
    init_req  = 1'b1;
    ao        = '0;
    ao_target = '0;
    cycle();
    init_req = 1'b0;
    exp_q.delete();
    fd_due    = -1;
    model_ptr = '0;
    base_ptr  = '0;
    cycle();
    check("abort_flags", 32'({dv, busy, frame_done}), 32'd0);
    check("abort_ch1a", 32'(ch1a), 32'd0);
    repeat (4) cycle();
    check("abort_no_done", 32'(fd_cnt), 32'd0);

    // Overrun: level 1026 sets the flag, which holds until init.
    ao        = 11'd513;
    ao_target = ao;
    repeat (3) cycle();
    check("ovr_level", 32'(level), 32'd1026);
    check("ovr_set", 32'(overrun), 32'd1);
    ao        = '0;
    ao_target = ao;
    repeat (3) cycle();
    check("ovr_level_back", 32'(level), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    init_req = 1'b1;
    cycle();
    init_req = 1'b0;
    cycle();
    check("ovr_cleared", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
